// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_BITS = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [DIV_BITS-1:0] DZ_QUOT = {DIV_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, quot} left, trial-subtract, restore on borrow.
module div_step
    import div_pkg::*;
#(
    parameter int BITS = DIV_BITS
) (
    input  logic [BITS-1:0] rem_i,
    input  logic [BITS-1:0] quot_i,
    input  logic [BITS-1:0] divisor_i,
    output logic [BITS-1:0] rem_o,
    output logic [BITS-1:0] quot_o
);

    logic [BITS:0]   shifted;
    logic [BITS+1:0] trial;
    logic            borrow;

    assign shifted = {rem_i, quot_i[BITS-1]};
    assign trial   = {1'b0, shifted} - {2'b00, divisor_i};
    assign borrow  = trial[BITS+1];

    // Either result is below the divisor, so the low BITS bits hold it exactly.
    assign rem_o  = borrow ? shifted[BITS-1:0] : trial[BITS-1:0];
    assign quot_o = {quot_i[BITS-2:0], ~borrow};

endmodule

// File: rtl/div.sv
// Sequential signed/unsigned 32-bit divider feeding HI (remainder) and LO (quotient).
module div
    import div_pkg::*;
#(
    parameter int BITS  = DIV_BITS,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            signed_op,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS-1:0] hi,
    output logic [BITS-1:0] lo,
    output logic            busy,
    output logic            done,
    output logic            div_zero
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BITS-1:0]  rem_q, rem_d;
    logic [BITS-1:0]  quot_q, quot_d;
    logic [BITS-1:0]  dvsr_q, dvsr_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             dz_q, dz_d;
    logic [BITS-1:0]  hi_q, hi_d;
    logic [BITS-1:0]  lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [BITS-1:0]  a_mag, b_mag;
    logic [BITS-1:0]  step_rem, step_quot;

    assign a_mag = (signed_op && a[BITS-1]) ? (-a) : a;
    assign b_mag = (signed_op && b[BITS-1]) ? (-b) : b;

    div_step #(.BITS(BITS)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        dvsr_d     = dvsr_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    if (b == '0) begin
                        // Result is known now; one SIGN cycle keeps busy up until done.
                        lo_d       = DZ_QUOT;
                        hi_d       = a;
                        div_zero_d = 1'b1;
                        dz_d       = 1'b1;
                        state_d    = SIGN;
                    end else begin
                        dz_d       = 1'b0;
                        quot_neg_d = signed_op & (a[BITS-1] ^ b[BITS-1]);
                        rem_neg_d  = signed_op & a[BITS-1];
                        rem_d      = '0;
                        quot_d     = a_mag;
                        dvsr_d     = b_mag;
                        cnt_d      = CNT_W'(BITS);
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (!dz_q) begin
                    lo_d = quot_neg_q ? (-quot_q) : quot_q;
                    hi_d = rem_neg_q ? (-rem_q) : rem_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            dvsr_q     <= dvsr_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;
    assign busy     = (state_q == RUN) || (state_q == SIGN);
    assign done     = (state_q == DONE);

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential 32-bit integer divider; the inverse operation to the datapath's multiplier.
- Feeds the HI/LO pair: LO = quotient, HI = remainder.
- Supports signed (DIV) and unsigned (DIVU) operation.
- Radix-2 restoring algorithm: one quotient bit per clock, so the control unit stalls on `busy` and resumes on `done`.

Parameters:
- BITS, 32, operand/result width.
- CNT_W, 6, iteration counter width (must satisfy CNT_W ≥ clog2(BITS)+1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  begin a division; sampled only in IDLE.
- signed_op  input  1  1 = signed (DIV), 0 = unsigned (DIVU).
- a  input  BITS  dividend.
- b  input  BITS  divisor.
- hi  output  BITS  remainder.
- lo  output  BITS  quotient.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse when hi/lo become valid.
- div_zero  output  1  high with done when b == 0; held until the next start.

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0.
- Reset asserted mid-operation aborts the division immediately.
- State machine: IDLE, RUN, SIGN, DONE.
- IDLE:
  - On start at edge E0: capture operands, clear div_zero, assert busy.
  - If b == 0: lo = all-ones, hi = a, div_zero = 1, go to DONE. done is high between E0+1 and E0+2.
  - Else:
    - Latch sign_q = signed_op & (a[31]^b[31]) and sign_r = signed_op & a[31].
    - Load |a| and |b|; magnitudes are used only when signed_op = 1, otherwise raw values.
    - Clear the partial remainder; set counter = BITS; go to RUN.
- RUN, one iteration per edge:
  - Shift {rem, quot} left by 1.
  - trial = rem − divisor, computed at BITS+1 bits.
  - If trial ≥ 0: rem = trial and quot LSB = 1. Else restore rem and quot LSB = 0.
  - Decrement the counter. After the iteration that brings it to 0, go to SIGN (32 iterations, edges E1..E32).
- SIGN (edge E33):
  - lo = sign_q ? −quot : quot.
  - hi = sign_r ? −rem : rem.
  - Go to DONE.
- DONE:
  - done = 1, busy = 0 for exactly one cycle (between E33 and E34), then IDLE.
- Latency from the start edge to done: 33 cycles (normal), 1 cycle (divide by zero).
- Rounding and sign rules:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Invariant: a == lo*b + hi, modulo 2^BITS.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This falls out of the magnitude path; no trap is raised.
- Output holding: hi, lo and div_zero hold their values through IDLE until the next accepted start. They are not updated during RUN; internal working registers are separate from the output registers.
- start while busy (RUN/SIGN/DONE): ignored; no restart, no queuing.
- start in the same cycle as reset: reset wins.
- Operands a, b and signed_op may change after E0 without effect.

Decomposition:
- Shared package `div_pkg`:
  - state enum (IDLE = 2'd0, RUN = 2'd1, SIGN = 2'd2, DONE = 2'd3);
  - BITS default;
  - the all-ones divide-by-zero quotient constant.
- One natural sub-module, `div_step`: combinational single restoring iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - Instantiated once in the RUN datapath.
- The sign handling (abs and negate) stays inline.

Test Plan:
- Basic signed: signed_op = 1, a = 100, b = 7.
  - Expected: lo = 14, hi = 2; busy high for exactly 33 cycles; done a single pulse at E0+33.
- Signed negative: a = −100 (0xFFFFFF9C), b = 7.
  - Expected: lo = 0xFFFFFFF2 (−14), hi = 0xFFFFFFFE (−2).
  - Repeat with b = −7: lo = 14, hi = −2.
- Signed vs unsigned: a = 0xFFFFFFFF, b = 2.
  - signed_op = 0: lo = 0x7FFFFFFF, hi = 1.
  - signed_op = 1: lo = 0, hi = 0xFFFFFFFF.
- Overflow corner: signed, a = 0x80000000, b = 0xFFFFFFFF.
  - Expected: lo = 0x80000000, hi = 0, div_zero = 0.
- Divide by zero: a = 0x12345678, b = 0.
  - Expected: done at E0+1, div_zero = 1, lo = 0xFFFFFFFF, hi = 0x12345678.
  - A following normal start clears div_zero.
- Control robustness:
  - Pulse start again at E5 of a running division: ignored, and the original result is correct.
  - Assert reset at E10 of another division: busy, done, hi and lo go to 0 immediately, state returns to IDLE, and the next start completes normally.
